press_pattern_gen: RTL and testbench

- Transmit-side counterpart of the short/long press classifier.
- Accepts one-cycle short/long requests, queues them, and replays each as a timed high level on out_level: a short or long "press", each followed by a fixed low gap.
- Drives buzzer/LED feedback and serves as a press stimulus source for the classifier, on the 10 kHz tick domain.

---
 rtl/press_pattern_gen.sv | 162 ++++++++++++++++
 tb/tb_press_pattern_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/press_pattern_gen.sv
// rtl/press_pattern_gen.sv - queued short/long press pattern generator
//
// Queues one-cycle short/long requests and replays each one as a timed high
// level on out_level, followed by a fixed low gap.
//
// Ports:
//   clk_10000Hz  in   10 kHz clock, all state changes on its rising edge
//   rst_n        in   asynchronous active-low reset
//   req_short    in   one-cycle request to enqueue a short symbol
//   req_long     in   one-cycle request to enqueue a long symbol (wins if both)
//   cancel       in   flush the queue and abort the current symbol
//   out_level    out  generated press level, 1 = pressed
//   busy         out  1 while a mark or gap is being played
//   full         out  queue occupancy == DEPTH
//   dropped      out  one-cycle pulse when a request is discarded
//   count        out  queue occupancy, 0..DEPTH
module press_pattern_gen #(
  parameter int SHORT_TICKS = 2000,
  parameter int LONG_TICKS  = 30000,
  parameter int GAP_TICKS   = 2000,
  parameter int DEPTH       = 4,
  parameter int CW          = 15
) (
  input  logic                     clk_10000Hz,
  input  logic                     rst_n,
  input  logic                     req_short,
  input  logic                     req_long,
  input  logic                     cancel,
  output logic                     out_level,
  output logic                     busy,
  output logic                     full,
  output logic                     dropped,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  // Counters count down to zero, so each phase loads its length minus one.
  localparam logic [CW-1:0] SHORT_LOAD = CW'(SHORT_TICKS - 1);
  localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_TICKS - 1);
  localparam logic [NW-1:0] DEPTH_N    = NW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [DEPTH-1:0] mem;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            head;
  logic [NW-1:0]   count_next;

  // Push acceptance looks only at the registered count, so a pop in the
  // same cycle never makes room for that cycle's request.
  always_comb begin
    push_req   = req_short | req_long;
    push_ok    = push_req && (count != DEPTH_N);
    pop        = (count != '0) &&
                 ((state == IDLE) || ((state == SPACE) && (cnt == '0)));
    head       = mem[rd_ptr];
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + NW'(1);
    end else if (!push_ok && pop) begin
      count_next = count - NW'(1);
    end
  end

  always_ff @(posedge clk_10000Hz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_level <= 1'b0;
      busy      <= 1'b0;
      full      <= 1'b0;
      dropped   <= 1'b0;
    end else if (cancel) begin
      // Flush wins over everything, including a request in the same cycle,
      // which is discarded silently rather than reported as dropped.
      state     <= IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_level <= 1'b0;
      busy      <= 1'b0;
      full      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      dropped <= push_req && !push_ok;
      if (push_ok) begin
        mem[wr_ptr] <= req_long;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == DEPTH_N);

      case (state)
        IDLE: begin
          if (pop) begin
            cnt       <= head ? LONG_LOAD : SHORT_LOAD;
            out_level <= 1'b1;
            busy      <= 1'b1;
            state     <= MARK;
          end else begin
            cnt       <= '0;
            out_level <= 1'b0;
            busy      <= 1'b0;
          end
        end
        MARK: begin
          if (cnt == '0) begin
            cnt       <= GAP_LOAD;
            out_level <= 1'b0;
            state     <= SPACE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SPACE: begin
          if (cnt == '0) begin
            // Chain straight into the next mark so the gap stays exact.
            if (pop) begin
              cnt       <= head ? LONG_LOAD : SHORT_LOAD;
              out_level <= 1'b1;
              state     <= MARK;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          out_level <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_pattern_gen.sv
// tb/tb_press_pattern_gen.sv - directed self-checking bench for press_pattern_gen
`timescale 1ns/1ps
module tb_press_pattern_gen;

  localparam int S = 4;
  localparam int L = 10;
  localparam int G = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_short = 1'b0;
  logic       req_long = 1'b0;
  logic       cancel = 1'b0;
  logic       out_level;
  logic       busy;
  logic       full;
  logic       dropped;
  logic [2:0] count;

  int compared = 0;
  int mismatched = 0;

  press_pattern_gen #(
    .SHORT_TICKS(S),
    .LONG_TICKS(L),
    .GAP_TICKS(G),
    .DEPTH(4),
    .CW(8)
  ) dut (
    .clk_10000Hz(clk),
    .rst_n(rst_n),
    .req_short(req_short),
    .req_long(req_long),
    .cancel(cancel),
    .out_level(out_level),
    .busy(busy),
    .full(full),
    .dropped(dropped),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Length of the current run of out_level==lvl while busy, bounded.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (out_level === lvl && busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  // Number of rising edges of out_level until busy drops, bounded.
  task automatic count_marks(output int m);
    logic prev;
    int   n;
    m = 0;
    n = 0;
    prev = out_level;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
      if (out_level === 1'b1 && prev === 1'b0) m++;
      prev = out_level;
    end
  endtask

  int n;
  int hi_seen;

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_out", out_level, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_dropped", dropped, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    tick();
    check("idle_out", out_level, 0);
    check("idle_busy", busy, 0);

    // Single short
    req_short = 1'b1;
    tick();
    req_short = 1'b0;
    check("t1_count_enq", count, 1);
    check("t1_out_before", out_level, 0);
    tick();
    check("t1_out_rise", out_level, 1);
    check("t1_busy", busy, 1);
    check("t1_count_pop", count, 0);
    run_len(1'b1, n);
    check("t1_mark_len", n, S);
    run_len(1'b0, n);
    check("t1_gap_len", n, G);
    check("t1_busy_end", busy, 0);
    check("t1_count_end", count, 0);

    // Back-to-back long then short, push coinciding with pop
    req_long = 1'b1;
    tick();
    req_long = 1'b0;
    req_short = 1'b1;
    tick();
    req_short = 1'b0;
    check("t2_count_pushpop", count, 1);
    check("t2_out_rise", out_level, 1);
    run_len(1'b1, n);
    check("t2_mark1_len", n, L);
    run_len(1'b0, n);
    check("t2_gap1_len", n, G);
    check("t2_no_idle_busy", busy, 1);
    check("t2_no_idle_out", out_level, 1);
    check("t2_count_mid", count, 0);
    run_len(1'b1, n);
    check("t2_mark2_len", n, S);
    run_len(1'b0, n);
    check("t2_gap2_len", n, G);
    check("t2_busy_end", busy, 0);

    // Overflow: six shorts on consecutive cycles
    req_short = 1'b1;
    tick();
    check("t3_count_e1", count, 1);
    tick();
    check("t3_count_e2", count, 1);
    check("t3_out_e2", out_level, 1);
    check("t3_full_e2", full, 0);
    tick();
    check("t3_count_e3", count, 2);
    tick();
    check("t3_count_e4", count, 3);
    tick();
    check("t3_count_e5", count, 4);
    check("t3_full_e5", full, 1);
    check("t3_dropped_e5", dropped, 0);
    tick();
    req_short = 1'b0;
    check("t3_count_e6", count, 4);
    check("t3_full_e6", full, 1);
    check("t3_dropped_e6", dropped, 1);
    tick();
    check("t3_dropped_e7", dropped, 0);
    check("t3_count_e7", count, 4);
    count_marks(n);
    check("t3_remaining_marks", n, 4);
    check("t3_count_end", count, 0);
    check("t3_full_end", full, 0);

    // Simultaneous short+long makes one long entry
    req_short = 1'b1;
    req_long = 1'b1;
    tick();
    req_short = 1'b0;
    req_long = 1'b0;
    check("t4_count_one", count, 1);
    tick();
    check("t4_count_pop", count, 0);
    run_len(1'b1, n);
    check("t4_mark_len", n, L);
    run_len(1'b0, n);
    check("t4_gap_len", n, G);
    check("t4_busy_end", busy, 0);

    // Cancel mid-mark with a full queue and a same-cycle request
    req_long = 1'b1;
    repeat (5) tick();
    req_long = 1'b0;
    check("t5_full_before", full, 1);
    check("t5_out_before", out_level, 1);
    cancel = 1'b1;
    req_short = 1'b1;
    tick();
    cancel = 1'b0;
    req_short = 1'b0;
    check("t5_out", out_level, 0);
    check("t5_count", count, 0);
    check("t5_busy", busy, 0);
    check("t5_full", full, 0);
    check("t5_dropped", dropped, 0);
    hi_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_level !== 1'b0 || dropped !== 1'b0) hi_seen++;
    end
    check("t5_quiet_after", hi_seen, 0);
    req_short = 1'b1;
    tick();
    req_short = 1'b0;
    tick();
    run_len(1'b1, n);
    check("t5_fresh_mark_len", n, S);
    run_len(1'b0, n);
    check("t5_fresh_gap_len", n, G);

    // Async reset mid-space with two queued
    req_short = 1'b1;
    repeat (3) tick();
    req_short = 1'b0;
    repeat (3) tick();
    check("t6_pre_out", out_level, 0);
    check("t6_pre_busy", busy, 1);
    check("t6_pre_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_count", count, 0);
    check("t6_async_out", out_level, 0);
    rst_n = 1'b1;
    hi_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_level !== 1'b0 || busy !== 1'b0) hi_seen++;
    end
    check("t6_quiet_after", hi_seen, 0);

    // Async reset mid-mark drops the level without a clock edge
    req_long = 1'b1;
    tick();
    req_long = 1'b0;
    tick();
    check("t7_pre_out", out_level, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_async_out", out_level, 0);
    check("t7_async_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
